add16_mp_seq: RTL and testbench
===============================

Name: add16_mp_seq

Overview:
- Sequencing controller that performs multi-precision add/subtract by time-multiplexing one external 16-bit ripple adder (a, b, cin -> sum, cout).
- Processes one 16-bit word per clock, least-significant word first, and chains the carry through a carry register.
- Sits between the CPU execute stage and the shared adder; provides a start/busy/done handshake and a full-width registered result with flags.

Parameters:
- W, 16, adder word width; must match the external adder.
- WORDS, 4, number of words per operand; operand width is W*WORDS, and WORDS >= 2.
- IW, 2, index counter width; must satisfy 2^IW >= WORDS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  W*WORDS  operand A; sampled with start.
- b  input  W*WORDS  operand B; sampled with start.
- add_a  output  W  to adder a; current word of latched A.
- add_b  output  W  to adder b; current word of latched B, inverted when subtracting.
- add_cin  output  1  to adder cin; the carry register.
- add_sum  input  W  from adder sum.
- add_cout  input  1  from adder cout.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- result  output  W*WORDS  registered result; held until the next accepted start.
- cout  output  1  final carry out; for subtraction, 1 means no borrow.
- overflow  output  1  signed two's-complement overflow of the full-width operation.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE, idx=0, carry=0, busy=0, done=0, result=0, cout=0, overflow=0, internal operand registers=0. Reset takes priority over everything and aborts any operation in progress; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge T0:
  - latch a, b, op_sub;
  - set carry=op_sub and idx=0;
  - move to RUN.
- IDLE, start=0: stay in IDLE.
- Adder drive (combinational from registers):
  - add_a = A[idx*W +: W];
  - add_b = B[idx*W +: W] XOR {W{sub}};
  - add_cin = carry.
  - In IDLE and DONE these outputs still follow the registers; the adder is don't-care in those states.
- RUN, each edge:
  - result[idx*W +: W] <= add_sum;
  - carry <= add_cout;
  - idx <= idx+1.
  - On the edge that processes idx=WORDS-1, also:
    - cout <= add_cout;
    - overflow <= (A_msb == Beff_msb) && (add_sum[W-1] != A_msb), where Beff_msb is the MSB of the inverted-or-not B word;
    - move to DONE.
- DONE: done=1 for exactly this one cycle, then return to IDLE at the next edge.
- Latency: the accepting edge is T0. Words are processed on edges T1..T_WORDS. done is high between edges T_WORDS and T_WORDS+1. For WORDS=4, done is high during the 5th cycle after start is asserted.
- start while busy (RUN or DONE) is ignored, not queued. Back-to-back operations need start to be high in IDLE; minimum issue interval is WORDS+2 cycles.
- a, b and op_sub may change freely after the accepting edge; the latched copies are used.
- result, cout and overflow change only during RUN.
  - Partial result words are visible during RUN and are not valid until done.
  - After done they hold until the next accepted start.
- Arithmetic is modulo 2^(W*WORDS); the final carry is not folded into result.
- idx never exceeds WORDS-1 while in RUN, and is reset to 0 on accept.

Test Plan:
- WORDS=4. Add 0x0000_0000_0000_FFFF + 0x0000_0000_0000_0001 -> result=0x0000_0000_0001_0000, cout=0, overflow=0; done pulses exactly 1 cycle, 5 cycles after start; busy high for 5 cycles.
- Subtract 0x0000_0000_0000_0000 - 0x0000_0000_0000_0001 -> result=0xFFFF_FFFF_FFFF_FFFF, cout=0 (borrow), overflow=0. Also check add_cin=1 on the first RUN cycle.
- Add 0x7FFF_FFFF_FFFF_FFFF + 0x0000_0000_0000_0001 -> result=0x8000_0000_0000_0000, overflow=1, cout=0. Then add 0xFFFF_FFFF_FFFF_FFFF + 0x0000_0000_0000_0001 -> result=0, cout=1, overflow=0.
- Hold start high and change a/b during RUN; start a second operation (0x1234 + 0x1111) while in DONE -> the first result is unaffected by the operand changes; the DONE-cycle start is ignored; a start re-asserted in IDLE yields result=0x0000_0000_0000_2345.
- Pull rst_n low on the 2nd RUN cycle of an add -> next cycle busy=0, done=0, result=0, cout=0. No done pulse ever appears for the aborted operation, and a subsequent start completes normally.
- Subtract 0x8000_0000_0000_0000 - 0x0000_0000_0000_0001 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, cout=1.

Source files
------------

// File: rtl/add16_mp_seq.sv
// Multi-precision add/subtract sequencer: time-multiplexes one external W-bit
// adder over WORDS words, least-significant word first, chaining the carry.
module add16_mp_seq #(
  parameter int W     = 16,
  parameter int WORDS = 4,
  parameter int IW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic [W*WORDS-1:0]   a,
  input  logic [W*WORDS-1:0]   b,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_cin,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic                 done,
  output logic [W*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    sub;
  logic [WORDS-1:0][W-1:0] a_q, b_q, res_q;
  logic                    last;
  logic                    accept;

  assign last   = (idx == IW'(WORDS - 1));
  assign accept = (state == IDLE) && start;

  // Adder drive follows the registers in every state; only RUN consumes it.
  assign add_a   = a_q[idx];
  assign add_b   = b_q[idx] ^ {W{sub}};
  assign add_cin = carry;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = res_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the operand and result arrays are plain flops, not RAM, so they
  // take the reset like any other register and come up as all zeros.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      sub      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sub   <= op_sub;
      carry <= op_sub;
      idx   <= '0;
    end else if (state == RUN) begin
      res_q[idx] <= add_sum;
      carry      <= add_cout;
      // Wrap on the last word so idx always stays a legal word index.
      idx        <= last ? '0 : idx + IW'(1);
      if (last) begin
        cout     <= add_cout;
        overflow <= (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
      end
    end
  end

endmodule

// File: tb/tb_add16_mp_seq.sv
// Self-checking bench for add16_mp_seq: models the shared adder, runs a
// directed vector table, corner sequences and random ops against a 64-bit model.
module tb_add16_mp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_sub;
  logic [63:0] a, b;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        busy, done;
  logic [63:0] result;
  logic        cout, overflow;

  int errors = 0;
  int checks = 0;

  add16_mp_seq #(.W(16), .WORDS(4), .IW(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .a(a), .b(b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .done(done), .result(result),
    .cout(cout), .overflow(overflow)
  );

  // The shared external ripple adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] r;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width unsigned and signed arithmetic on whole operands.
  function automatic void model(input logic [63:0] x, input logic [63:0] y, input logic s,
                                output logic [63:0] r, output logic c, output logic o);
    logic [64:0]        u;
    logic signed [65:0] sv;
    if (s) begin
      u  = {1'b0, x} - {1'b0, y};
      sv = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
      c  = (x >= y);
    end else begin
      u  = {1'b0, x} + {1'b0, y};
      sv = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
      c  = u[64];
    end
    r = u[63:0];
    o = (sv != $signed({{2{r[63]}}, r}));
  endfunction

  // Waits (bounded) for done; returns negedges counted since the accept edge.
  task automatic wait_done(output int lat, output int busy_n);
    bit seen = 1'b0;
    lat    = 0;
    busy_n = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      if (n > 1) @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end
    end
  endtask

  task automatic do_op(input logic [63:0] x, input logic [63:0] y, input logic s,
                       output logic [63:0] r, output logic c, output logic o);
    int lat, busy_n;
    @(negedge clk);
    a = x; b = y; op_sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_add_cin", 64'(add_cin), 64'(s));
    check("first_add_a", 64'(add_a), 64'(x[15:0]));
    check("first_add_b", 64'(add_b), 64'(y[15:0] ^ {16{s}}));
    wait_done(lat, busy_n);
    check("done_latency", 64'(lat), 64'd5);
    check("busy_cycles", 64'(busy_n), 64'd5);
    r = result; c = cout; o = overflow;
    @(negedge clk);
    check("done_single_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    check("result_held", result, r);
  endtask

  initial begin
    logic [63:0] r, er, first_a, first_b;
    logic        c, o, ec, eo;
    int          lat, busy_n;
    bit          seen;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    vecs[4] = '{64'h0000_0000_0000_1234, 64'h0000_0000_0000_1111, 1'b0, 64'h0000_0000_0000_2345, 1'b0, 1'b0};
    vecs[5] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_add_cin", 64'(add_cin), 64'd0);
    check("reset_add_a", 64'(add_a), 64'd0);
    check("reset_add_b", 64'(add_b), 64'd0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, c, o);
      check($sformatf("vec%0d_result", i), r, vecs[i].r);
      check($sformatf("vec%0d_cout", i), 64'(c), 64'(vecs[i].c));
      check($sformatf("vec%0d_overflow", i), 64'(o), 64'(vecs[i].o));
    end

    // Reset on the 2nd RUN cycle aborts the operation with no done pulse.
    @(negedge clk);
    a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, r, c, o);
    check("after_abort_result", r, 64'h1234_5678_9ABC_DF00);
    check("after_abort_cout", 64'(c), 64'd0);

    // start held high, operands churn during RUN, start in DONE is ignored.
    first_a = 64'hDEAD_BEEF_CAFE_F00D;
    first_b = 64'h0F0F_F0F0_1234_8765;
    model(first_a, first_b, 1'b0, er, ec, eo);
    @(negedge clk);
    a = first_a; b = first_b; op_sub = 1'b0; start = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op_sub = 1'($urandom);
      end
    end
    check("hold_done_seen", 64'(seen), 64'd1);
    check("hold_result", result, er);
    check("hold_cout", 64'(cout), 64'(ec));
    a = 64'h1234; b = 64'h1111; op_sub = 1'b0;
    @(negedge clk);
    check("done_start_ignored", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("idle_start_accepted", 64'(busy), 64'd1);
    wait_done(lat, busy_n);
    check("second_latency", 64'(lat), 64'd5);
    check("second_result", result, 64'h0000_0000_0000_2345);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [63:0] x, y;
      logic        s;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: x = 64'hFFFF_FFFF_FFFF_FFFF;
        1: y = {48'd0, 16'($urandom)};
        2: x = {1'b0, {63{1'b1}}};
        3: y = x;
        default: ;
      endcase
      model(x, y, s, er, ec, eo);
      do_op(x, y, s, r, c, o);
      check($sformatf("rand%0d_result", i), r, er);
      check($sformatf("rand%0d_cout", i), 64'(c), 64'(ec));
      check($sformatf("rand%0d_overflow", i), 64'(o), 64'(eo));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
